mips_cpu_control_fsm: RTL and testbench
=======================================

MIPS_CPU_CONTROL_FSM -- requirements
Module: mips_cpu_control_fsm

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: instr_word  input  32  memory read data, captured as the instruction in FETCH.
REQ-004 SHALL have port: mem_waitrequest  input  1  memory stall; high = current access not complete.
REQ-005 SHALL have port: sig_branch  input  1  ALU branch-taken flag, sampled in EXEC.
REQ-006 SHALL have ports: opcode  output  6, alu_control  output  6, shamt  output  5, immediate  output  16  IR fields [31:26], [5:0], [10:6], [15:0] driven to the ALU.
REQ-007 SHALL have ports: rs_addr, rt_addr, wr_addr  output  5 each  register file addresses.
REQ-008 SHALL have ports: reg_write_en, ir_write, pc_write, mem_read, mem_write, mem_addr_sel  output  1 each  datapath strobes; mem_addr_sel 0 = PC, 1 = ALU result.
REQ-009 SHALL have ports: pc_src  output  2  (00 PC+4, 01 branch target, 10 jump target, 11 rs register); active  output  1; state  output  3.

Function
REQ-010 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
REQ-011 IDLE SHALL go to FETCH unconditionally after one cycle.
REQ-012 In FETCH, mem_read=1 and mem_addr_sel=0; the FSM SHALL remain in FETCH while mem_waitrequest=1.
REQ-013 On the first FETCH cycle with mem_waitrequest=0, the FSM SHALL pulse ir_write=1 and pc_write=1 with pc_src=00, latch instr_word into the IR, and go to DECODE.
REQ-014 IR-derived outputs (opcode, alu_control, shamt, immediate, rs_addr, rt_addr) SHALL be valid from DECODE onward and hold until the next IR capture.
REQ-015 DECODE SHALL go to EXEC in one cycle with no strobes asserted.
REQ-016 EXEC transitions:
- R-type ALU (opcode 0, funct 21/23/24/25/26/02/03/00/2B) and I-type ALU (09, 0A, 0B, 0C, 0D, 0E, 0F) -> WB.
- lw (23h) / sw (2Bh) -> MEM.
- beq (04h) / bne (05h): pc_write=1 with pc_src=01 iff sig_branch=1 -> FETCH.
- j (02h): pc_write=1, pc_src=10 -> FETCH.
- jr (opcode 0, funct 08h): pc_write=1, pc_src=11 -> FETCH; if rs_addr=0 -> HALT instead, with no pc_write.
REQ-017 Unsupported opcode/funct SHALL return to FETCH with no write strobes asserted.
REQ-018 In MEM, mem_addr_sel=1; mem_read=1 for lw or mem_write=1 for sw; the FSM SHALL hold in MEM while mem_waitrequest=1.
REQ-019 MEM exit on mem_waitrequest=0: lw -> WB, sw -> FETCH.
REQ-020 WB SHALL assert reg_write_en=1 for exactly one cycle, then go to FETCH.
REQ-021 wr_addr SHALL be IR[15:11] for R-type and IR[20:16] for I-type and lw.
REQ-022 WB SHALL suppress reg_write_en when wr_addr=0.
REQ-023 HALT SHALL be terminal: active=0 and all strobes 0 until reset.
REQ-024 active SHALL be 1 in all states except IDLE and HALT.
REQ-025 Strobes SHALL be decoded from the registered state only; there is no combinational path from instr_word to any strobe.
REQ-026 mem_read and mem_write SHALL never be high in the same cycle.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, IR=0, and all strobes, active, and pc_src to 0, regardless of clk.
REQ-028 Reset asserted mid-access (FETCH or MEM) SHALL abort the access with no ir_write, pc_write, or reg_write_en pulse.
REQ-029 After rst_n rises, the first FETCH SHALL occur on the second rising edge.

Verification
REQ-030 Fetch addu instr_word=0x00851021, waitrequest=0 -> states 1,2,3,5,1; rs_addr=4, rt_addr=5, alu_control=0x21; reg_write_en=1 in WB with wr_addr=2.
REQ-031 lw 0x8C220004 with waitrequest=1 for 3 MEM cycles -> 4 MEM cycles with mem_read=1, mem_addr_sel=1; then WB with wr_addr=2, immediate=0x0004.
REQ-032 beq 0x10000003: sig_branch=1 -> pc_write=1, pc_src=01 in EXEC; sig_branch=0 -> pc_write=0; both return to FETCH.
REQ-033 jr $0 (0x00000008) -> state=6, active=0, no pc_write; further clocks with random inputs -> outputs unchanged.
REQ-034 sw 0xAC220000 with rst_n pulsed low during MEM -> mem_write drops immediately; state=0; no reg_write_en; FETCH resumes 2 edges after release.
REQ-035 addiu 0x24000005 (rt=0) -> WB reached with reg_write_en=0.

Source files
------------

// File: rtl/mips_cpu_control_fsm.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/writeback
// and decodes datapath strobes from the registered state and instruction register.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr_word                 memory read data, captured into the IR in FETCH
//   mem_waitrequest            memory stall (1 = access not complete)
//   sig_branch                 ALU branch-taken flag, used in EXEC
//   opcode/alu_control/shamt/immediate, rs_addr/rt_addr/wr_addr   IR fields
//   reg_write_en, ir_write, pc_write, mem_read, mem_write, mem_addr_sel   strobes
//   pc_src                     00 PC+4, 01 branch, 10 jump, 11 rs register
//   active, state              run indicator and current state code
module mips_cpu_control_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_word,
  input  logic        mem_waitrequest,
  input  logic        sig_branch,
  output logic [5:0]  opcode,
  output logic [5:0]  alu_control,
  output logic [4:0]  shamt,
  output logic [15:0] immediate,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [4:0]  wr_addr,
  output logic        reg_write_en,
  output logic        ir_write,
  output logic        pc_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_addr_sel,
  output logic [1:0]  pc_src,
  output logic        active,
  output logic [2:0]  state
);

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned REG_W   = 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_J   = 2'b10;
  localparam logic [1:0] PC_SRC_RS  = 2'b11;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [INSTR_W-1:0] r_ir;

  logic [OP_W-1:0]    w_op;
  logic [OP_W-1:0]    w_funct;
  logic               w_rtype;
  logic               w_r_alu;
  logic               w_i_alu;
  logic               w_lw;
  logic               w_sw;
  logic               w_branch;
  logic               w_jump;
  logic               w_jr;

  // State register and instruction register; IR loads only on the fetch handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (ir_write) begin
        r_ir <= instr_word;
      end
    end
  end

  // IR field breakout to the ALU and register file.
  assign w_op        = r_ir[31:26];
  assign w_funct     = r_ir[5:0];
  assign opcode      = w_op;
  assign alu_control = w_funct;
  assign shamt       = r_ir[10:6];
  assign immediate   = r_ir[15:0];
  assign rs_addr     = r_ir[25:21];
  assign rt_addr     = r_ir[20:16];
  assign w_rtype     = (w_op == OP_W'(0));
  assign wr_addr     = w_rtype ? r_ir[15:11] : r_ir[20:16];
  assign state       = r_state;

  // Instruction class decode from the registered IR.
  always_comb begin
    w_r_alu  = 1'b0;
    w_i_alu  = 1'b0;
    w_lw     = 1'b0;
    w_sw     = 1'b0;
    w_branch = 1'b0;
    w_jump   = 1'b0;
    w_jr     = 1'b0;
    if (w_rtype) begin
      case (w_funct)
        6'h21, 6'h23, 6'h24, 6'h25, 6'h26,
        6'h02, 6'h03, 6'h00, 6'h2B: w_r_alu = 1'b1;
        6'h08:                      w_jr    = 1'b1;
        default:                    ;
      endcase
    end else begin
      case (w_op)
        6'h09, 6'h0A, 6'h0B, 6'h0C,
        6'h0D, 6'h0E, 6'h0F: w_i_alu  = 1'b1;
        6'h23:               w_lw     = 1'b1;
        6'h2B:               w_sw     = 1'b1;
        6'h04, 6'h05:        w_branch = 1'b1;
        6'h02:               w_jump   = 1'b1;
        default:             ;
      endcase
    end
  end

  // Next-state and strobe decode; strobes depend only on registered state/IR
  // plus the memory stall and branch flag.
  always_comb begin
    w_state_nxt  = r_state;
    reg_write_en = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = 1'b0;
    pc_src       = PC_SRC_SEQ;
    active       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        active   = 1'b1;
        mem_read = 1'b1;
        if (!mem_waitrequest) begin
          ir_write    = 1'b1;
          pc_write    = 1'b1;
          pc_src      = PC_SRC_SEQ;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        active      = 1'b1;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        active      = 1'b1;
        w_state_nxt = S_FETCH;
        if (w_r_alu || w_i_alu) begin
          w_state_nxt = S_WB;
        end else if (w_lw || w_sw) begin
          w_state_nxt = S_MEM;
        end else if (w_branch) begin
          pc_write = sig_branch;
          pc_src   = sig_branch ? PC_SRC_BR : PC_SRC_SEQ;
        end else if (w_jump) begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_J;
        end else if (w_jr) begin
          // jr $0 is the halt convention: stop without redirecting the PC.
          if (rs_addr == REG_W'(0)) begin
            w_state_nxt = S_HALT;
          end else begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_RS;
          end
        end
      end
      S_MEM: begin
        active       = 1'b1;
        mem_addr_sel = 1'b1;
        mem_read     = w_lw;
        mem_write    = w_sw;
        if (!mem_waitrequest) begin
          w_state_nxt = w_lw ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        active       = 1'b1;
        reg_write_en = (wr_addr != REG_W'(0));
        w_state_nxt  = S_FETCH;
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_cpu_control_fsm.sv
// Scoreboard bench for mips_cpu_control_fsm: a driver issues instructions with
// random stalls/branch flags and queues the expected per-cycle behaviour; a
// monitor on the falling edge pops and compares.
module tb_mips_cpu_control_fsm;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_word;
  logic        mem_waitrequest;
  logic        sig_branch;
  logic [5:0]  opcode;
  logic [5:0]  alu_control;
  logic [4:0]  shamt;
  logic [15:0] immediate;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  wr_addr;
  logic        reg_write_en;
  logic        ir_write;
  logic        pc_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_addr_sel;
  logic [1:0]  pc_src;
  logic        active;
  logic [2:0]  state;

  mips_cpu_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .instr_word(instr_word),
    .mem_waitrequest(mem_waitrequest), .sig_branch(sig_branch),
    .opcode(opcode), .alu_control(alu_control), .shamt(shamt), .immediate(immediate),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .wr_addr(wr_addr),
    .reg_write_en(reg_write_en), .ir_write(ir_write), .pc_write(pc_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr_sel(mem_addr_sel),
    .pc_src(pc_src), .active(active), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {C_RALU, C_IALU, C_LW, C_SW, C_BR, C_J, C_JR, C_BAD, C_JR0} cls_t;

  typedef struct packed {
    logic [2:0]  st;
    logic        act;
    logic        rwe;
    logic        irw;
    logic        pcw;
    logic        mrd;
    logic        mwr;
    logic        mas;
    logic [1:0]  pcs;
    logic        chkf;
    logic [31:0] ir;
    logic        chkw;
    logic [4:0]  wr;
  } exp_t;

  localparam logic [5:0] R_FN   [9] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h02, 6'h03, 6'h00, 6'h2B};
  localparam logic [5:0] BAD_OP [7] = '{6'h01, 6'h03, 6'h06, 6'h07, 6'h10, 6'h20, 6'h3F};
  localparam logic [5:0] BAD_FN [5] = '{6'h20, 6'h22, 6'h2A, 6'h09, 6'h01};

  exp_t        q[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h required %h", nm, $time, got, want);
    end
  endtask

  // Instruction class as the reference sees it.
  function automatic cls_t classify(input logic [31:0] ir);
    logic [5:0] op;
    logic [5:0] fn;
    op = ir[31:26];
    fn = ir[5:0];
    if (op == 6'h00) begin
      if (fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h02, 6'h03, 6'h00, 6'h2B}) return C_RALU;
      if (fn == 6'h08) return (ir[25:21] == 5'd0) ? C_JR0 : C_JR;
      return C_BAD;
    end
    if (op >= 6'h09 && op <= 6'h0F) return C_IALU;
    if (op == 6'h23) return C_LW;
    if (op == 6'h2B) return C_SW;
    if (op == 6'h04 || op == 6'h05) return C_BR;
    if (op == 6'h02) return C_J;
    return C_BAD;
  endfunction

  function automatic logic [31:0] gen(input cls_t c);
    logic [25:0] rnd;
    logic [31:0] w;
    rnd = 26'($urandom);
    case (c)
      C_RALU:  w = {6'h00, rnd[25:6], R_FN[$urandom_range(0, 8)]};
      C_IALU:  w = {6'(9 + $urandom_range(0, 6)), rnd};
      C_LW:    w = {6'h23, rnd};
      C_SW:    w = {6'h2B, rnd};
      C_BR:    w = {6'($urandom_range(4, 5)), rnd};
      C_J:     w = {6'h02, rnd};
      C_JR:    w = {6'h00, 5'($urandom_range(1, 31)), rnd[20:6], 6'h08};
      default: begin
        if ($urandom_range(0, 1) == 1) w = {BAD_OP[$urandom_range(0, 6)], rnd};
        else                           w = {6'h00, rnd[25:6], BAD_FN[$urandom_range(0, 4)]};
      end
    endcase
    return w;
  endfunction

  function automatic exp_t blank(input logic [2:0] st, input logic act);
    exp_t e;
    e = '0;
    e.st = st;
    e.act = act;
    return e;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one cycle of inputs, queue the expectation, advance to just past the next edge.
  task automatic cyc(input exp_t e, input logic wr, input logic br, input logic [31:0] iw);
    mem_waitrequest = wr;
    sig_branch      = br;
    instr_word      = iw;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Called with rst_n low: one IDLE cycle in reset, release, one IDLE cycle after.
  task automatic idle_after_reset();
    exp_t e;
    e = blank(3'd0, 1'b0);
    e.chkf = 1'b1;
    e.ir = 32'h0;
    cyc(e, rbit(), rbit(), $urandom);
    rst_n = 1'b1;
    cyc(e, rbit(), rbit(), $urandom);
  endtask

  // Asynchronous reset in the middle of a memory access.
  task automatic mid_reset();
    mem_waitrequest = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_mem_write", 64'(mem_write), 64'd0);
    chk("rst_async_state", 64'(state), 64'd0);
    chk("rst_async_strobes", 64'({reg_write_en, ir_write, pc_write, mem_read, mem_addr_sel, pc_src, active}), 64'd0);
    @(posedge clk);
    #1;
    idle_after_reset();
  endtask

  task automatic run_instr(input logic [31:0] ir, input int fw, input int mw, input logic br, input logic rst_in_mem);
    cls_t       c;
    exp_t       e;
    logic [4:0] wr_exp;
    c = classify(ir);
    wr_exp = (c == C_RALU) ? ir[15:11] : ir[20:16];
    for (int i = 0; i < fw; i++) begin
      e = blank(3'd1, 1'b1);
      e.mrd = 1'b1;
      cyc(e, 1'b1, rbit(), $urandom);
    end
    e = blank(3'd1, 1'b1);
    e.mrd = 1'b1; e.irw = 1'b1; e.pcw = 1'b1; e.pcs = 2'b00;
    cyc(e, 1'b0, rbit(), ir);
    e = blank(3'd2, 1'b1);
    e.chkf = 1'b1; e.ir = ir;
    cyc(e, rbit(), rbit(), $urandom);
    e = blank(3'd3, 1'b1);
    e.chkf = 1'b1; e.ir = ir;
    case (c)
      C_BR:    begin e.pcw = br;   e.pcs = 2'b01; end
      C_J:     begin e.pcw = 1'b1; e.pcs = 2'b10; end
      C_JR:    begin e.pcw = 1'b1; e.pcs = 2'b11; end
      default: ;
    endcase
    cyc(e, rbit(), br, $urandom);
    if (c == C_LW || c == C_SW) begin
      for (int k = 0; k <= mw; k++) begin
        e = blank(3'd4, 1'b1);
        e.chkf = 1'b1; e.ir = ir; e.mas = 1'b1;
        e.mrd = (c == C_LW);
        e.mwr = (c == C_SW);
        if (rst_in_mem && k == 1) begin
          mid_reset();
          return;
        end
        cyc(e, (k < mw), rbit(), $urandom);
      end
    end
    if (c == C_RALU || c == C_IALU || c == C_LW) begin
      e = blank(3'd5, 1'b1);
      e.chkf = 1'b1; e.ir = ir;
      e.chkw = 1'b1; e.wr = wr_exp;
      e.rwe = (wr_exp != 5'd0);
      cyc(e, rbit(), rbit(), $urandom);
    end
  endtask

  // Monitor: compare queued expectations mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("state_strobes",
            64'({state, active, reg_write_en, ir_write, pc_write, mem_read, mem_write, mem_addr_sel}),
            64'({e.st, e.act, e.rwe, e.irw, e.pcw, e.mrd, e.mwr, e.mas}));
        if (e.pcw) chk("pc_src", 64'(pc_src), 64'(e.pcs));
        if (e.chkf)
          chk("ir_fields",
              64'({opcode, rs_addr, rt_addr, immediate, shamt, alu_control}),
              64'({e.ir, e.ir[10:6], e.ir[5:0]}));
        if (e.chkw) chk("wr_addr", 64'(wr_addr), 64'(e.wr));
      end
    end
  end

  initial begin
    cls_t c;
    rst_n           = 1'b0;
    mem_waitrequest = 1'b0;
    sig_branch      = 1'b0;
    instr_word      = 32'h0;
    @(posedge clk);
    #1;
    idle_after_reset();

    run_instr(32'h00851021, 0, 0, 1'b0, 1'b0);  // addu $2,$4,$5
    run_instr(32'h8C220004, 1, 3, 1'b0, 1'b0);  // lw with 3 stall cycles
    run_instr(32'h10000003, 0, 0, 1'b1, 1'b0);  // beq taken
    run_instr(32'h10000003, 0, 0, 1'b0, 1'b0);  // beq not taken
    run_instr(32'h24000005, 0, 0, 1'b0, 1'b0);  // addiu to $0
    run_instr(32'hAC220000, 0, 3, 1'b0, 1'b1);  // sw aborted by reset
    run_instr(32'h08000010, 2, 0, 1'b0, 1'b0);  // j
    run_instr(32'h03E00008, 0, 0, 1'b0, 1'b0);  // jr $31

    for (int n = 0; n < 80; n++) begin
      c = cls_t'($urandom_range(0, 7));
      run_instr(gen(c), $urandom_range(0, 2), $urandom_range(0, 3), rbit(), 1'b0);
    end

    run_instr(32'h00000008, 0, 0, 1'b0, 1'b0);  // jr $0 -> halt
    for (int n = 0; n < 8; n++) begin
      cyc(blank(3'd6, 1'b0), rbit(), rbit(), $urandom);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
